// File: rtl/osd_mam_burst_split_if.sv
// osd_mam_burst_split_if
//
// One MAM-style memory port: a request channel plus streaming write and read
// data channels, each with its own valid/ready handshake.
//
// Signals:
//   req_valid / req_ready     request handshake
//   req_rw                    0 read, 1 write
//   req_addr   [ADDR_WIDTH]   base byte address
//   req_burst                 0 single beat, 1 incremental burst
//   req_beats  [14]           burst length in words
//   write_valid / write_ready write data handshake
//   write_data [DATA_WIDTH], write_strb [DATA_WIDTH/8]
//   read_valid / read_ready   read data handshake
//   read_data  [DATA_WIDTH]
//
// Modports:
//   master  issues requests, sources write data, sinks read data
//   slave   accepts requests, sinks write data, sources read data
interface osd_mam_burst_split_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
);
    localparam int BW = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_rw;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_burst;
    logic [13:0]           req_beats;

    logic                  write_valid;
    logic                  write_ready;
    logic [DATA_WIDTH-1:0] write_data;
    logic [BW-1:0]         write_strb;

    logic                  read_valid;
    logic                  read_ready;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output req_valid, req_rw, req_addr, req_burst, req_beats,
        input  req_ready,
        output write_valid, write_data, write_strb,
        input  write_ready,
        input  read_valid, read_data,
        output read_ready
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_burst, req_beats,
        output req_ready,
        input  write_valid, write_data, write_strb,
        output write_ready,
        output read_valid, read_data,
        input  read_ready
    );
endinterface

// File: rtl/osd_mam_burst_split.sv
// osd_mam_burst_split
//
// Request-shaping stage in front of the MAM Wishbone bus interface. A single
// upstream request of up to 16383 beats is reissued downstream as a series of
// sub-requests. No sub-request is longer than MAX_BEATS, and none crosses a
// BOUNDARY-byte aligned address. Write and read data stream through
// combinationally, enabled only while a sub-request is in its data phase.
// Single-beat requests pass through as one unsplit request.
//
// Parameters:
//   DATA_WIDTH  data width in bits (8, 16 or 32)
//   ADDR_WIDTH  byte address width
//   MAX_BEATS   maximum beats per sub-request (1..8191)
//   BOUNDARY    byte boundary no sub-request may cross (power of two)
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   in_bus   slave modport, upstream request / write / read channels
//   out_bus  master modport, downstream sub-request / write / read channels
module osd_mam_burst_split #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BEATS  = 16,
    parameter int BOUNDARY   = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    osd_mam_burst_split_if.slave         in_bus,
    osd_mam_burst_split_if.master        out_bus
);
    localparam int                    BW         = DATA_WIDTH / 8;
    localparam int                    BW_LOG2    = $clog2(BW);
    localparam logic [31:0]           BOUND_SIZE = 32'(BOUNDARY);
    localparam logic [31:0]           BOUND_MASK = 32'(BOUNDARY - 1);
    localparam logic [13:0]           MAX_LEN    = 14'(MAX_BEATS);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BW - 1));

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA
    } state_t;

    state_t                state;
    logic                  rw_q;
    logic                  burst_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [13:0]           remaining_q;
    logic [13:0]           len_q;
    logic [13:0]           cnt_q;
    logic                  req_ready_q;
    logic                  req_valid_q;

    logic                  is_write;
    logic                  is_read;
    logic                  wr_hs;
    logic                  rd_hs;
    logic                  beat_hs;
    logic                  last_hs;
    logic [13:0]           remaining_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [13:0]           accept_beats;
    logic [ADDR_WIDTH-1:0] accept_addr;

    // Length of the next sub-request: bounded by what is left, by MAX_BEATS
    // and by the number of words up to the next BOUNDARY-aligned address.
    function automatic logic [13:0] calc_len(
        input logic [13:0]           rem,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  burst
    );
        logic [31:0] offset;
        logic [31:0] room;
        logic [13:0] len;
        offset = 32'(addr) & BOUND_MASK;
        room   = (BOUND_SIZE - offset) >> BW_LOG2;
        len    = rem;
        if (len > MAX_LEN) begin
            len = MAX_LEN;
        end
        if (32'(len) > room) begin
            len = room[13:0];
        end
        if (!burst) begin
            len = 14'd1;
        end
        return len;
    endfunction

    assign is_write = (state == DATA) && rw_q;
    assign is_read  = (state == DATA) && !rw_q;

    // Data channels are pure pass-through during DATA and forced to zero
    // otherwise, so nothing leaks downstream before its request is taken.
    assign out_bus.write_valid = is_write && in_bus.write_valid;
    assign in_bus.write_ready  = is_write && out_bus.write_ready;
    assign out_bus.write_data  = is_write ? in_bus.write_data : '0;
    assign out_bus.write_strb  = !is_write ? '0 : (burst_q ? '1 : in_bus.write_strb);

    assign in_bus.read_valid   = is_read && out_bus.read_valid;
    assign out_bus.read_ready  = is_read && in_bus.read_ready;
    assign in_bus.read_data    = is_read ? out_bus.read_data : '0;

    assign wr_hs   = is_write && in_bus.write_valid && out_bus.write_ready;
    assign rd_hs   = is_read && out_bus.read_valid && in_bus.read_ready;
    assign beat_hs = wr_hs || rd_hs;
    assign last_hs = beat_hs && (cnt_q == 14'd1);

    assign remaining_next = remaining_q - len_q;
    assign addr_next      = addr_q + (ADDR_WIDTH'(len_q) << BW_LOG2);

    // A zero length or a non-burst request both move exactly one word.
    assign accept_beats = (!in_bus.req_burst || (in_bus.req_beats == 14'd0)) ? 14'd1
                                                                             : in_bus.req_beats;
    assign accept_addr  = in_bus.req_addr & ALIGN_MASK;

    assign in_bus.req_ready   = req_ready_q;
    assign out_bus.req_valid  = req_valid_q;
    assign out_bus.req_rw     = rw_q;
    assign out_bus.req_addr   = addr_q;
    assign out_bus.req_burst  = burst_q;
    assign out_bus.req_beats  = len_q;

    // Request fields only change on state transitions, so they hold steady
    // while a sub-request is stalled in ISSUE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rw_q        <= 1'b0;
            burst_q     <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            req_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_ready_q && in_bus.req_valid) begin
                        rw_q        <= in_bus.req_rw;
                        burst_q     <= in_bus.req_burst;
                        addr_q      <= accept_addr;
                        remaining_q <= accept_beats;
                        len_q       <= calc_len(accept_beats, accept_addr, in_bus.req_burst);
                        req_ready_q <= 1'b0;
                        req_valid_q <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (out_bus.req_ready) begin
                        req_valid_q <= 1'b0;
                        cnt_q       <= len_q;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (beat_hs) begin
                        cnt_q <= cnt_q - 14'd1;
                        if (last_hs) begin
                            remaining_q <= remaining_next;
                            addr_q      <= addr_next;
                            if (remaining_next == 14'd0) begin
                                req_ready_q <= 1'b1;
                                state       <= IDLE;
                            end else begin
                                len_q       <= calc_len(remaining_next, addr_next, burst_q);
                                req_valid_q <= 1'b1;
                                state       <= ISSUE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_osd_mam_burst_split.sv
// tb_osd_mam_burst_split
//
// Directed bench for osd_mam_burst_split with DATA_WIDTH=16, MAX_BEATS=16,
// BOUNDARY=1024. The bench plays both the upstream requester and the
// downstream memory. Write words are 16'hA000+n and read words are
// 16'h5000+n, so the order of the stream can be checked against its index.
module tb_osd_mam_burst_split;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk_i = ~clk_i;

    osd_mam_burst_split_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) up_bus ();
    osd_mam_burst_split_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) dn_bus ();

    osd_mam_burst_split #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(32),
        .MAX_BEATS (16),
        .BOUNDARY  (1024)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .in_bus (up_bus),
        .out_bus(dn_bus)
    );

    // Observations of the last transaction: {rw, burst, beats, addr} per
    // accepted sub-request, and the data stream at the receiving side.
    logic [47:0] cap_req[$];
    logic [15:0] cap_data[$];
    logic [1:0]  cap_strb[$];
    int          stable_err;
    int          overlap_err;
    int          early_ready;
    int          first_req_delay;
    int          ready_delay;
    int          xfer_cycles;
    bit          timed_out;

    task automatic idle_inputs();
        up_bus.req_valid   = 1'b0;
        up_bus.req_rw      = 1'b0;
        up_bus.req_addr    = '0;
        up_bus.req_burst   = 1'b0;
        up_bus.req_beats   = '0;
        up_bus.write_valid = 1'b0;
        up_bus.write_data  = '0;
        up_bus.write_strb  = '0;
        up_bus.read_ready  = 1'b0;
        dn_bus.req_ready   = 1'b0;
        dn_bus.write_ready = 1'b0;
        dn_bus.read_valid  = 1'b0;
        dn_bus.read_data   = '0;
    endtask

    // Drives one upstream request to completion (or until abort_at source
    // beats have been moved) and records what happened on both sides.
    task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [13:0] beats,
                           input logic burst, input logic [1:0] strb, input int stall,
                           input bit rand_rdy, input int abort_at);
        int total;
        int src_cnt;
        int snk_cnt;
        int stall_cnt;
        int accept_cyc;
        int last_cyc;
        bit accepted;
        bit stalled;
        bit done;
        logic [47:0] held;
        cap_req.delete();
        cap_data.delete();
        cap_strb.delete();
        stable_err = 0; overlap_err = 0; early_ready = 0;
        first_req_delay = -1; ready_delay = -1; xfer_cycles = -1; timed_out = 1'b0;
        total = (beats == 14'd0 || !burst) ? 1 : int'(beats);
        src_cnt = 0; snk_cnt = 0; stall_cnt = 0; accept_cyc = 0; last_cyc = 0;
        accepted = 1'b0; stalled = 1'b0; done = 1'b0; held = '0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk_i);
            up_bus.req_valid = !accepted;
            up_bus.req_rw    = rw;
            up_bus.req_addr  = addr;
            up_bus.req_burst = burst;
            up_bus.req_beats = beats;
            dn_bus.req_ready = 1'b0;
            if (dn_bus.req_valid) begin
                if (stalled && {dn_bus.req_rw, dn_bus.req_burst, dn_bus.req_beats, dn_bus.req_addr} !== held)
                    stable_err++;
                if (stall_cnt < stall) stall_cnt++;
                else dn_bus.req_ready = 1'b1;
            end
            up_bus.write_valid = rw && (src_cnt < total);
            up_bus.write_data  = 16'hA000 + 16'(src_cnt);
            up_bus.write_strb  = strb;
            dn_bus.write_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            dn_bus.read_valid  = !rw && (src_cnt < total);
            dn_bus.read_data   = 16'h5000 + 16'(src_cnt);
            up_bus.read_ready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (dn_bus.req_valid && dn_bus.write_valid) overlap_err++;
            if (accepted && up_bus.req_ready && snk_cnt < total) early_ready++;
            if (accepted && first_req_delay < 0 && dn_bus.req_valid) first_req_delay = cyc - accept_cyc;
            if (!accepted && up_bus.req_valid && up_bus.req_ready) begin
                accepted = 1'b1;
                accept_cyc = cyc;
            end
            if (accepted && snk_cnt >= total && up_bus.req_ready) begin
                ready_delay = cyc - last_cyc;
                xfer_cycles = last_cyc - accept_cyc;
                done = 1'b1;
            end
            if (dn_bus.req_valid) begin
                if (dn_bus.req_ready) begin
                    cap_req.push_back({dn_bus.req_rw, dn_bus.req_burst, dn_bus.req_beats, dn_bus.req_addr});
                    stall_cnt = 0;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = {dn_bus.req_rw, dn_bus.req_burst, dn_bus.req_beats, dn_bus.req_addr};
                end
            end
            if (rw) begin
                if (up_bus.write_valid && up_bus.write_ready) src_cnt++;
                if (dn_bus.write_valid && dn_bus.write_ready) begin
                    cap_data.push_back(dn_bus.write_data);
                    cap_strb.push_back(dn_bus.write_strb);
                    snk_cnt++;
                    last_cyc = cyc;
                end
            end else begin
                if (dn_bus.read_valid && dn_bus.read_ready) src_cnt++;
                if (up_bus.read_valid && up_bus.read_ready) begin
                    cap_data.push_back(up_bus.read_data);
                    snk_cnt++;
                    last_cyc = cyc;
                end
            end
            if (abort_at >= 0 && src_cnt >= abort_at) begin
                @(posedge clk_i);
                done = 1'b1;
            end
        end
        if (!done) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if (up_bus.req_ready !== 1'b0) begin
            n_bad++; $display("[TB] FAIL rst_req_ready: got %b want 0", up_bus.req_ready);
        end
        n_cmp++;
        if ({dn_bus.req_valid, dn_bus.req_addr, dn_bus.req_beats, dn_bus.write_valid, dn_bus.read_ready} !== '0) begin
            n_bad++; $display("[TB] FAIL rst_outputs: got %h want 0",
                              {dn_bus.req_valid, dn_bus.req_addr, dn_bus.req_beats, dn_bus.write_valid, dn_bus.read_ready});
        end
        rst_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if (up_bus.req_ready !== 1'b1) begin
            n_bad++; $display("[TB] FAIL rel_req_ready: got %b want 1", up_bus.req_ready);
        end
    endtask

    task automatic test_write_burst();
        logic [47:0] exp_req [3];
        exp_req[0] = {1'b1, 1'b1, 14'd16, 32'h0000_0000};
        exp_req[1] = {1'b1, 1'b1, 14'd16, 32'h0000_0020};
        exp_req[2] = {1'b1, 1'b1, 14'd8,  32'h0000_0040};
        run_txn(1'b1, 32'h0, 14'd40, 1'b1, 2'b01, 0, 1'b0, -1);
        idle_inputs();
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("[TB] FAIL wr40_timeout: got %b want 0", timed_out); end
        n_cmp++; if (cap_req.size() != 3) begin n_bad++; $display("[TB] FAIL wr40_nreq: got %0d want 3", cap_req.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < cap_req.size()) begin
                n_cmp++;
                if (cap_req[i] !== exp_req[i]) begin
                    n_bad++; $display("[TB] FAIL wr40_req%0d: got %h want %h", i, cap_req[i], exp_req[i]);
                end
            end
        end
        n_cmp++; if (cap_data.size() != 40) begin n_bad++; $display("[TB] FAIL wr40_nwords: got %0d want 40", cap_data.size()); end
        for (int i = 0; i < cap_data.size(); i++) begin
            n_cmp++;
            if (cap_data[i] !== 16'hA000 + 16'(i) || cap_strb[i] !== 2'b11) begin
                n_bad++; $display("[TB] FAIL wr40_word%0d: got %h/%b want %h/11", i, cap_data[i], cap_strb[i], 16'hA000 + 16'(i));
            end
        end
        n_cmp++; if (first_req_delay != 1) begin n_bad++; $display("[TB] FAIL wr40_req_lat: got %0d want 1", first_req_delay); end
        n_cmp++; if (xfer_cycles != 43) begin n_bad++; $display("[TB] FAIL wr40_cycles: got %0d want 43", xfer_cycles); end
        n_cmp++; if (ready_delay != 1) begin n_bad++; $display("[TB] FAIL wr40_ready_lat: got %0d want 1", ready_delay); end
        n_cmp++; if (early_ready != 0) begin n_bad++; $display("[TB] FAIL wr40_early_ready: got %0d want 0", early_ready); end
        n_cmp++; if (overlap_err != 0) begin n_bad++; $display("[TB] FAIL wr40_overlap: got %0d want 0", overlap_err); end
    endtask

    task automatic test_read_boundary();
        logic [47:0] exp_req [2];
        exp_req[0] = {1'b0, 1'b1, 14'd4, 32'h0000_03F8};
        exp_req[1] = {1'b0, 1'b1, 14'd6, 32'h0000_0400};
        run_txn(1'b0, 32'h3F8, 14'd10, 1'b1, 2'b00, 0, 1'b0, -1);
        idle_inputs();
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("[TB] FAIL rd10_timeout: got %b want 0", timed_out); end
        n_cmp++; if (cap_req.size() != 2) begin n_bad++; $display("[TB] FAIL rd10_nreq: got %0d want 2", cap_req.size()); end
        for (int i = 0; i < 2; i++) begin
            if (i < cap_req.size()) begin
                n_cmp++;
                if (cap_req[i] !== exp_req[i]) begin
                    n_bad++; $display("[TB] FAIL rd10_req%0d: got %h want %h", i, cap_req[i], exp_req[i]);
                end
            end
        end
        n_cmp++; if (cap_data.size() != 10) begin n_bad++; $display("[TB] FAIL rd10_nwords: got %0d want 10", cap_data.size()); end
        for (int i = 0; i < cap_data.size(); i++) begin
            n_cmp++;
            if (cap_data[i] !== 16'h5000 + 16'(i)) begin
                n_bad++; $display("[TB] FAIL rd10_word%0d: got %h want %h", i, cap_data[i], 16'h5000 + 16'(i));
            end
        end
        n_cmp++; if (xfer_cycles != 12) begin n_bad++; $display("[TB] FAIL rd10_cycles: got %0d want 12", xfer_cycles); end
        n_cmp++; if (ready_delay != 1) begin n_bad++; $display("[TB] FAIL rd10_ready_lat: got %0d want 1", ready_delay); end
    endtask

    task automatic test_single_write();
        run_txn(1'b1, 32'h3FE, 14'd5, 1'b0, 2'b01, 0, 1'b0, -1);
        idle_inputs();
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("[TB] FAIL single_timeout: got %b want 0", timed_out); end
        n_cmp++; if (cap_req.size() != 1) begin n_bad++; $display("[TB] FAIL single_nreq: got %0d want 1", cap_req.size()); end
        if (cap_req.size() > 0) begin
            n_cmp++;
            if (cap_req[0] !== {1'b1, 1'b0, 14'd1, 32'h0000_03FE}) begin
                n_bad++; $display("[TB] FAIL single_req: got %h want %h", cap_req[0], {1'b1, 1'b0, 14'd1, 32'h0000_03FE});
            end
        end
        n_cmp++; if (cap_data.size() != 1) begin n_bad++; $display("[TB] FAIL single_nwords: got %0d want 1", cap_data.size()); end
        if (cap_data.size() > 0) begin
            n_cmp++;
            if (cap_data[0] !== 16'hA000 || cap_strb[0] !== 2'b01) begin
                n_bad++; $display("[TB] FAIL single_word: got %h/%b want a000/01", cap_data[0], cap_strb[0]);
            end
        end
        n_cmp++; if (overlap_err != 0) begin n_bad++; $display("[TB] FAIL single_overlap: got %0d want 0", overlap_err); end
        n_cmp++; if (xfer_cycles != 2) begin n_bad++; $display("[TB] FAIL single_cycles: got %0d want 2", xfer_cycles); end
    endtask

    task automatic test_zero_beats();
        run_txn(1'b0, 32'h201, 14'd0, 1'b1, 2'b00, 0, 1'b0, -1);
        idle_inputs();
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("[TB] FAIL zero_timeout: got %b want 0", timed_out); end
        n_cmp++; if (cap_req.size() != 1) begin n_bad++; $display("[TB] FAIL zero_nreq: got %0d want 1", cap_req.size()); end
        if (cap_req.size() > 0) begin
            n_cmp++;
            if (cap_req[0] !== {1'b0, 1'b1, 14'd1, 32'h0000_0200}) begin
                n_bad++; $display("[TB] FAIL zero_req: got %h want %h", cap_req[0], {1'b0, 1'b1, 14'd1, 32'h0000_0200});
            end
        end
        n_cmp++; if (cap_data.size() != 1) begin n_bad++; $display("[TB] FAIL zero_nwords: got %0d want 1", cap_data.size()); end
    endtask

    task automatic test_backpressure();
        logic [47:0] exp_req [2];
        exp_req[0] = {1'b0, 1'b1, 14'd16, 32'h0000_0100};
        exp_req[1] = {1'b0, 1'b1, 14'd4,  32'h0000_0120};
        run_txn(1'b0, 32'h100, 14'd20, 1'b1, 2'b00, 5, 1'b1, -1);
        idle_inputs();
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_timeout: got %b want 0", timed_out); end
        n_cmp++; if (cap_req.size() != 2) begin n_bad++; $display("[TB] FAIL bp_nreq: got %0d want 2", cap_req.size()); end
        for (int i = 0; i < 2; i++) begin
            if (i < cap_req.size()) begin
                n_cmp++;
                if (cap_req[i] !== exp_req[i]) begin
                    n_bad++; $display("[TB] FAIL bp_req%0d: got %h want %h", i, cap_req[i], exp_req[i]);
                end
            end
        end
        n_cmp++; if (cap_data.size() != 20) begin n_bad++; $display("[TB] FAIL bp_nwords: got %0d want 20", cap_data.size()); end
        for (int i = 0; i < cap_data.size(); i++) begin
            n_cmp++;
            if (cap_data[i] !== 16'h5000 + 16'(i)) begin
                n_bad++; $display("[TB] FAIL bp_word%0d: got %h want %h", i, cap_data[i], 16'h5000 + 16'(i));
            end
        end
        n_cmp++; if (stable_err != 0) begin n_bad++; $display("[TB] FAIL bp_stable: got %0d want 0", stable_err); end
        n_cmp++; if (first_req_delay != 1) begin n_bad++; $display("[TB] FAIL bp_req_lat: got %0d want 1", first_req_delay); end
        n_cmp++; if (early_ready != 0) begin n_bad++; $display("[TB] FAIL bp_early_ready: got %0d want 0", early_ready); end
    endtask

    task automatic test_wrap();
        logic [47:0] exp_req [2];
        exp_req[0] = {1'b0, 1'b1, 14'd2, 32'hFFFF_FFFC};
        exp_req[1] = {1'b0, 1'b1, 14'd2, 32'h0000_0000};
        run_txn(1'b0, 32'hFFFF_FFFC, 14'd4, 1'b1, 2'b00, 0, 1'b0, -1);
        idle_inputs();
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("[TB] FAIL wrap_timeout: got %b want 0", timed_out); end
        n_cmp++; if (cap_req.size() != 2) begin n_bad++; $display("[TB] FAIL wrap_nreq: got %0d want 2", cap_req.size()); end
        for (int i = 0; i < 2; i++) begin
            if (i < cap_req.size()) begin
                n_cmp++;
                if (cap_req[i] !== exp_req[i]) begin
                    n_bad++; $display("[TB] FAIL wrap_req%0d: got %h want %h", i, cap_req[i], exp_req[i]);
                end
            end
        end
        n_cmp++; if (cap_data.size() != 4) begin n_bad++; $display("[TB] FAIL wrap_nwords: got %0d want 4", cap_data.size()); end
        n_cmp++; if (xfer_cycles != 6) begin n_bad++; $display("[TB] FAIL wrap_cycles: got %0d want 6", xfer_cycles); end
    endtask

    task automatic test_reset_mid();
        run_txn(1'b1, 32'h40, 14'd16, 1'b1, 2'b11, 0, 1'b0, 7);
        n_cmp++; if (cap_data.size() != 7) begin n_bad++; $display("[TB] FAIL rmid_nwords: got %0d want 7", cap_data.size()); end
        // Keep every input active so gating faults would show on the outputs.
        @(negedge clk_i);
        rst_i = 1'b1;
        up_bus.req_valid   = 1'b1;
        up_bus.write_valid = 1'b1;
        up_bus.write_data  = 16'hBEEF;
        up_bus.write_strb  = 2'b11;
        up_bus.read_ready  = 1'b1;
        dn_bus.req_ready   = 1'b1;
        dn_bus.write_ready = 1'b1;
        dn_bus.read_valid  = 1'b1;
        dn_bus.read_data   = 16'h1234;
        @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if ({up_bus.req_ready, up_bus.write_ready, up_bus.read_valid, up_bus.read_data,
             dn_bus.req_valid, dn_bus.req_rw, dn_bus.req_addr, dn_bus.req_burst, dn_bus.req_beats,
             dn_bus.write_valid, dn_bus.write_data, dn_bus.write_strb, dn_bus.read_ready} !== '0) begin
            n_bad++;
            $display("[TB] FAIL rmid_outputs: got %h want 0",
                     {up_bus.req_ready, up_bus.write_ready, up_bus.read_valid, up_bus.read_data,
                      dn_bus.req_valid, dn_bus.req_rw, dn_bus.req_addr, dn_bus.req_burst, dn_bus.req_beats,
                      dn_bus.write_valid, dn_bus.write_data, dn_bus.write_strb, dn_bus.read_ready});
        end
        idle_inputs();
        rst_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if (up_bus.req_ready !== 1'b1) begin
            n_bad++; $display("[TB] FAIL rmid_req_ready: got %b want 1", up_bus.req_ready);
        end
        run_txn(1'b1, 32'h10, 14'd3, 1'b1, 2'b01, 0, 1'b0, -1);
        idle_inputs();
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_timeout: got %b want 0", timed_out); end
        n_cmp++; if (cap_req.size() != 1) begin n_bad++; $display("[TB] FAIL rmid_nreq: got %0d want 1", cap_req.size()); end
        if (cap_req.size() > 0) begin
            n_cmp++;
            if (cap_req[0] !== {1'b1, 1'b1, 14'd3, 32'h0000_0010}) begin
                n_bad++; $display("[TB] FAIL rmid_req: got %h want %h", cap_req[0], {1'b1, 1'b1, 14'd3, 32'h0000_0010});
            end
        end
        n_cmp++; if (cap_data.size() != 3) begin n_bad++; $display("[TB] FAIL rmid_after_nwords: got %0d want 3", cap_data.size()); end
        for (int i = 0; i < cap_data.size(); i++) begin
            n_cmp++;
            if (cap_data[i] !== 16'hA000 + 16'(i) || cap_strb[i] !== 2'b11) begin
                n_bad++; $display("[TB] FAIL rmid_word%0d: got %h/%b want %h/11", i, cap_data[i], cap_strb[i], 16'hA000 + 16'(i));
            end
        end
        n_cmp++; if (ready_delay != 1) begin n_bad++; $display("[TB] FAIL rmid_ready_lat: got %0d want 1", ready_delay); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting osd_mam_burst_split directed tests");
        test_reset();
        test_write_burst();
        test_read_boundary();
        test_single_write();
        test_zero_beats();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
